writeback_arbiter: RTL and testbench

Drives the single write port (`we`, `Rd_addr`, `Rd_data`) of the MIPS register file. It merges two result sources: the in-order pipeline writeback and a multi-cycle unit (mul/div). Multi-cycle results are buffered in a 2-entry skid FIFO and arbitrated against pipeline writes. A 32-entry scoreboard of pending multi-cycle destinations lets decode stall on RAW/WAW hazards.

---
 rtl/mips_pkg.sv | 16 +
 rtl/wb_skid_fifo.sv | 50 +++++
 rtl/writeback_arbiter.sv | 137 +++++++++++++
 tb/tb_writeback_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS register-file definitions.
// Holds register addressing constants and the writeback entry type.
package mips_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [XLEN-1:0]       data;
   } wb_entry_t;

endpackage

// File: rtl/wb_skid_fifo.sv
// Two-entry FIFO of writeback entries.
// Buffers multi-cycle results until the write port is free.
module wb_skid_fifo
   import mips_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  wb_entry_t push_entry,
   input  logic      pop,
   output wb_entry_t head,
   output logic      full,
   output logic      empty
);

   wb_entry_t  mem [2];
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] count;
   logic       do_push;
   logic       do_pop;

   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   // storage, pointers and occupancy; reset drops all buffered entries
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) mem[i] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_entry;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) rd_ptr <= ~rd_ptr;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write port arbiter: pipeline vs buffered mul/div results.
// Optional decode bypass from the write port when WB_BYPASS_EN is defined.
module writeback_arbiter
   import mips_pkg::*;
#(
   parameter int width      = XLEN,
   parameter int STARVE_MAX = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pipe_valid,
   input  logic [REG_ADDR_W-1:0] pipe_addr,
   input  logic [width-1:0]      pipe_data,
   input  logic                  mc_issue,
   input  logic [REG_ADDR_W-1:0] mc_issue_addr,
   input  logic                  mc_valid,
   output logic                  mc_ready,
   input  logic [REG_ADDR_W-1:0] mc_addr,
   input  logic [width-1:0]      mc_data,
   output logic                  stall_req,
   input  logic [REG_ADDR_W-1:0] Rs_addr,
   input  logic [REG_ADDR_W-1:0] Rt_addr,
   output logic                  rs_pending,
   output logic                  rt_pending,
   output logic                  rs_fwd_valid,
   output logic                  rt_fwd_valid,
   output logic [width-1:0]      rs_fwd_data,
   output logic [width-1:0]      rt_fwd_data,
   output logic                  we,
   output logic [REG_ADDR_W-1:0] Rd_addr,
   output logic [width-1:0]      Rd_data
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   logic                pipe_eff;
   logic                push;
   logic                pop;
   logic                fifo_full;
   logic                fifo_empty;
   wb_entry_t           mc_entry;
   wb_entry_t           head;
   logic                we_mc;
   logic [CNT_W-1:0]    starve_cnt;
   logic [NUM_REGS-1:0] pending;
   logic [NUM_REGS-1:0] pend_set;
   logic [NUM_REGS-1:0] pend_clr;
   logic                rs_hit;
   logic                rt_hit;

   assign pipe_eff      = pipe_valid & (pipe_addr != ZERO_REG);
   assign mc_ready      = ~fifo_full;
   assign push          = mc_valid & mc_ready;
   assign pop           = ~fifo_empty & ~pipe_eff;
   assign mc_entry.addr = mc_addr;
   assign mc_entry.data = XLEN'(mc_data);
   assign stall_req     = (starve_cnt >= CNT_W'(STARVE_MAX));

   wb_skid_fifo u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_entry (mc_entry),
      .pop        (pop),
      .head       (head),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

   // registered write port; pipeline always wins, addr 0 never writes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we      <= 1'b0;
         we_mc   <= 1'b0;
         Rd_addr <= ZERO_REG;
         Rd_data <= '0;
      end else if (pipe_eff) begin
         we      <= 1'b1;
         we_mc   <= 1'b0;
         Rd_addr <= pipe_addr;
         Rd_data <= pipe_data;
      end else if (pop) begin
         we      <= (head.addr != ZERO_REG);
         we_mc   <= (head.addr != ZERO_REG);
         Rd_addr <= head.addr;
         Rd_data <= width'(head.data);
      end else begin
         we    <= 1'b0;
         we_mc <= 1'b0;
      end
   end

   // count cycles the buffered head loses to the pipeline
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (fifo_empty || pop) begin
         starve_cnt <= '0;
      end else if (pipe_eff && !stall_req) begin
         starve_cnt <= starve_cnt + CNT_W'(1);
      end
   end

   // scoreboard set/clear masks; set is applied last so it wins
   always_comb begin
      pend_set = '0;
      pend_clr = '0;
      if (mc_issue && mc_issue_addr != ZERO_REG) pend_set[mc_issue_addr] = 1'b1;
      if (we_mc) pend_clr[Rd_addr] = 1'b1;
   end

   // pending destinations of in-flight multi-cycle ops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pending <= '0;
      else     pending <= (pending & ~pend_clr) | pend_set;
   end

`ifdef WB_BYPASS_EN
   assign rs_hit       = we & (Rd_addr != ZERO_REG) & (Rd_addr == Rs_addr);
   assign rt_hit       = we & (Rd_addr != ZERO_REG) & (Rd_addr == Rt_addr);
   assign rs_fwd_valid = rs_hit;
   assign rt_fwd_valid = rt_hit;
   assign rs_fwd_data  = Rd_data;
   assign rt_fwd_data  = Rd_data;
`else
   assign rs_hit       = 1'b0;
   assign rt_hit       = 1'b0;
   assign rs_fwd_valid = 1'b0;
   assign rt_fwd_valid = 1'b0;
   assign rs_fwd_data  = '0;
   assign rt_fwd_data  = '0;
`endif

   assign rs_pending = pending[Rs_addr] & ~rs_hit;
   assign rt_pending = pending[Rt_addr] & ~rt_hit;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: cycle table plus write-port scoreboard.
// Expectations follow WB_BYPASS_EN when the bench is built with it.
module tb_writeback_arbiter;

`ifdef WB_BYPASS_EN
   localparam int BP = 1;
`else
   localparam int BP = 0;
`endif
   localparam int NB = 1 - BP;

   typedef struct {
      bit          pv;
      logic [4:0]  pa;
      logic [31:0] pd;
      bit          iss;
      logic [4:0]  ia;
      bit          mv;
      logic [4:0]  ma;
      logic [31:0] md;
      logic [4:0]  rs;
      logic [4:0]  rt;
      bit          rdy;
      bit          st;
      bit          rsp;
      bit          rtp;
      bit          fv;
      bit          fvt;
      logic [31:0] fd;
   } vec_t;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pipe_valid = 1'b0;
   logic [4:0]  pipe_addr = '0;
   logic [31:0] pipe_data = '0;
   logic        mc_issue = 1'b0;
   logic [4:0]  mc_issue_addr = '0;
   logic        mc_valid = 1'b0;
   logic        mc_ready;
   logic [4:0]  mc_addr = '0;
   logic [31:0] mc_data = '0;
   logic        stall_req;
   logic [4:0]  Rs_addr = '0;
   logic [4:0]  Rt_addr = '0;
   logic        rs_pending;
   logic        rt_pending;
   logic        rs_fwd_valid;
   logic        rt_fwd_valid;
   logic [31:0] rs_fwd_data;
   logic [31:0] rt_fwd_data;
   logic        we;
   logic [4:0]  Rd_addr;
   logic [31:0] Rd_data;

   int total = 0;
   int bad   = 0;

   ent_t mq[$];
   ent_t wr_q[$];
   vec_t vt[$];

   writeback_arbiter #(.width(32), .STARVE_MAX(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .pipe_valid    (pipe_valid),
      .pipe_addr     (pipe_addr),
      .pipe_data     (pipe_data),
      .mc_issue      (mc_issue),
      .mc_issue_addr (mc_issue_addr),
      .mc_valid      (mc_valid),
      .mc_ready      (mc_ready),
      .mc_addr       (mc_addr),
      .mc_data       (mc_data),
      .stall_req     (stall_req),
      .Rs_addr       (Rs_addr),
      .Rt_addr       (Rt_addr),
      .rs_pending    (rs_pending),
      .rt_pending    (rt_pending),
      .rs_fwd_valid  (rs_fwd_valid),
      .rt_fwd_valid  (rt_fwd_valid),
      .rs_fwd_data   (rs_fwd_data),
      .rt_fwd_data   (rt_fwd_data),
      .we            (we),
      .Rd_addr       (Rd_addr),
      .Rd_data       (Rd_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
      end
   endtask

   function automatic vec_t mk(int pv, int pa, int pd, int iss, int ia, int mv, int ma, int md,
                               int rs, int rt, int rdy, int st, int rsp, int rtp, int fv, int fvt, int fd);
      vec_t v;
      v.pv  = (pv != 0);
      v.pa  = 5'(pa);
      v.pd  = 32'(pd);
      v.iss = (iss != 0);
      v.ia  = 5'(ia);
      v.mv  = (mv != 0);
      v.ma  = 5'(ma);
      v.md  = 32'(md);
      v.rs  = 5'(rs);
      v.rt  = 5'(rt);
      v.rdy = (rdy != 0);
      v.st  = (st != 0);
      v.rsp = (rsp != 0);
      v.rtp = (rtp != 0);
      v.fv  = (fv != 0);
      v.fvt = (fvt != 0);
      v.fd  = 32'(fd);
      return v;
   endfunction

   task automatic drive(input vec_t v);
      pipe_valid    = v.pv;
      pipe_addr     = v.pa;
      pipe_data     = v.pd;
      mc_issue      = v.iss;
      mc_issue_addr = v.ia;
      mc_valid      = v.mv;
      mc_addr       = v.ma;
      mc_data       = v.md;
      Rs_addr       = v.rs;
      Rt_addr       = v.rt;
   endtask

   task automatic check_vec(input int i, input vec_t v);
      string s;
      s = $sformatf("row%0d", i);
      chk({s, ".mc_ready"}, 32'(mc_ready), 32'(v.rdy));
      chk({s, ".stall_req"}, 32'(stall_req), 32'(v.st));
      chk({s, ".rs_pending"}, 32'(rs_pending), 32'(v.rsp));
      chk({s, ".rt_pending"}, 32'(rt_pending), 32'(v.rtp));
      chk({s, ".rs_fwd_valid"}, 32'(rs_fwd_valid), 32'(v.fv));
      chk({s, ".rt_fwd_valid"}, 32'(rt_fwd_valid), 32'(v.fvt));
`ifdef WB_BYPASS_EN
      if (v.fv) chk({s, ".rs_fwd_data"}, rs_fwd_data, v.fd);
`else
      chk({s, ".rs_fwd_data"}, rs_fwd_data, 32'd0);
`endif
   endtask

   // reference of the write port: pipeline first, then oldest buffered result
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         wr_q.delete();
      end else begin
         automatic ent_t e;
         automatic bit   rdy = (mq.size() < 2);
         if (pipe_valid && pipe_addr != 5'd0) begin
            wr_q.push_back({pipe_addr, pipe_data});
         end else if (mq.size() != 0) begin
            e = mq.pop_front();
            if (e.a != 5'd0) wr_q.push_back(e);
         end
         if (mc_valid && rdy) mq.push_back({mc_addr, mc_data});
      end
   end

   // compare every DUT write against the scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         if (wr_q.size() != 0) begin
            automatic ent_t e = wr_q.pop_front();
            chk("wr.we", 32'(we), 32'd1);
            chk("wr.addr", 32'(Rd_addr), 32'(e.a));
            chk("wr.data", Rd_data, e.d);
         end else begin
            chk("wr.idle_we", 32'(we), 32'd0);
         end
      end
   end

   initial begin
      vt.push_back(mk(1, 5, 'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      vt.push_back(mk(1, 0, 'h55, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      vt.push_back(mk(0, 0, 0, 1, 9, 0, 0, 0, 9, 9, 1, 0, 1, 1, 0, 0, 0));
      vt.push_back(mk(0, 0, 0, 0, 0, 1, 9, 'h1234, 9, 9, 1, 0, 1, 1, 0, 0, 0));
      vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 9, 1, 0, NB, NB, BP, BP, 'h1234));
      vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 9, 1, 0, 0, 0, 0, 0, 0));
      vt.push_back(mk(1, 1, 'h100, 0, 0, 1, 12, 'hA, 12, 0, 1, 0, 0, 0, 0, 0, 0));
      vt.push_back(mk(1, 2, 'h101, 0, 0, 0, 0, 0, 12, 0, 1, 0, 0, 0, 0, 0, 0));
      vt.push_back(mk(1, 3, 'h102, 0, 0, 0, 0, 0, 12, 0, 1, 0, 0, 0, 0, 0, 0));
      vt.push_back(mk(1, 4, 'h103, 0, 0, 0, 0, 0, 12, 0, 1, 0, 0, 0, 0, 0, 0));
      vt.push_back(mk(1, 5, 'h104, 0, 0, 0, 0, 0, 12, 0, 1, 1, 0, 0, 0, 0, 0));
      vt.push_back(mk(1, 6, 'h105, 0, 0, 0, 0, 0, 12, 0, 1, 1, 0, 0, 0, 0, 0));
      vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 12, 0, 1, 0, 0, 0, BP, 0, 'hA));
      vt.push_back(mk(1, 7, 'h200, 0, 0, 1, 13, 'hB1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      vt.push_back(mk(1, 8, 'h201, 0, 0, 1, 14, 'hB2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vt.push_back(mk(1, 10, 'h202, 0, 0, 1, 15, 'hB3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vt.push_back(mk(0, 0, 0, 0, 0, 1, 15, 'hB3, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      vt.push_back(mk(0, 0, 0, 0, 0, 1, 15, 'hB3, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      vt.push_back(mk(0, 0, 0, 1, 3, 0, 0, 0, 3, 0, 1, 0, 1, 0, 0, 0, 0));
      vt.push_back(mk(0, 0, 0, 0, 0, 1, 3, 'hC1, 3, 0, 1, 0, 1, 0, 0, 0, 0));
      vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0, NB, 0, BP, 0, 'hC1));
      vt.push_back(mk(0, 0, 0, 1, 3, 0, 0, 0, 3, 0, 1, 0, 1, 0, 0, 0, 0));
      vt.push_back(mk(0, 0, 0, 0, 0, 1, 3, 'hC2, 3, 0, 1, 0, 1, 0, 0, 0, 0));
      vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0, NB, 0, BP, 0, 'hC2));
      vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 0, 0, 0, 0, 0));
      vt.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      vt.push_back(mk(0, 0, 0, 0, 0, 1, 0, 'hDD, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));

      repeat (2) @(negedge clk);
      chk("rst.we", 32'(we), 32'd0);
      chk("rst.Rd_addr", 32'(Rd_addr), 32'd0);
      chk("rst.Rd_data", Rd_data, 32'd0);
      chk("rst.mc_ready", 32'(mc_ready), 32'd1);
      chk("rst.stall_req", 32'(stall_req), 32'd0);
      chk("rst.rs_fwd_valid", 32'(rs_fwd_valid), 32'd0);
      chk("rst.rt_fwd_data", rt_fwd_data, 32'd0);
      rst = 1'b0;

      foreach (vt[i]) begin
         drive(vt[i]);
         @(negedge clk);
         check_vec(i, vt[i]);
      end

      // fill the FIFO, starve it and mark r7 pending, then reset mid-cycle
      drive(mk(0, 0, 0, 1, 7, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      drive(mk(1, 1, 'h300, 0, 0, 1, 20, 'hE1, 7, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      drive(mk(1, 2, 'h301, 0, 0, 1, 21, 'hE2, 7, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         drive(mk(1, 3 + k, 'h302 + k, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0));
         @(negedge clk);
      end
      chk("pre.stall_req", 32'(stall_req), 32'd1);
      chk("pre.mc_ready", 32'(mc_ready), 32'd0);
      chk("pre.rs_pending", 32'(rs_pending), 32'd1);
      chk("pre.we", 32'(we), 32'd1);

      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0));
      #2 rst = 1'b1;
      #1;
      chk("mid.we", 32'(we), 32'd0);
      chk("mid.Rd_addr", 32'(Rd_addr), 32'd0);
      chk("mid.mc_ready", 32'(mc_ready), 32'd1);
      chk("mid.stall_req", 32'(stall_req), 32'd0);
      chk("mid.rs_pending", 32'(rs_pending), 32'd0);
      #1 rst = 1'b0;

      repeat (3) @(negedge clk);
      chk("post.rs_pending", 32'(rs_pending), 32'd0);
      chk("post.mc_ready", 32'(mc_ready), 32'd1);
      chk("post.sb_empty", 32'(wr_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
